// File: rtl/count_chk_pkg.sv
// Shared types and defaults for the count_checker block.
// Holds the checker FSM encoding and parameter defaults.
package count_chk_pkg;

  localparam int DEF_WIDTH  = 4;
  localparam int DEF_ERR_W  = 8;
  localparam int DEF_LOCK_N = 3;
  localparam int GR_W       = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    TRACK  = 2'd2,
    RESYNC = 2'd3
  } state_t;

endpackage

// File: rtl/count_checker_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Holds at all-ones once reached.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/count_checker.sv
// Step checker for an observed up/down counter.
// Tracks lock on consecutive good steps and counts mismatches.
module count_checker
  import count_chk_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int ERR_W  = DEF_ERR_W,
  parameter int LOCK_N = DEF_LOCK_N
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             m,
  input  logic [WIDTH-1:0] count,
  input  logic             clr,
  output logic             err,
  output logic             err_sticky,
  output logic [ERR_W-1:0] err_cnt,
  output logic             locked,
  output logic [1:0]       state
);

  localparam logic [GR_W-1:0] LOCK = GR_W'(LOCK_N);

  state_t           cur, nxt;
  logic [WIDTH-1:0] prev, prev_n, expd;
  logic             prev_m, prev_m_n;
  logic [GR_W-1:0]  run, run_n;
  logic             err_n, stk_n, lck_n, miss;

  always_comb begin
    expd     = prev_m ? prev + WIDTH'(1) : prev - WIDTH'(1);
    nxt      = cur;
    prev_n   = prev;
    prev_m_n = prev_m;
    run_n    = run;
    err_n    = 1'b0;
    stk_n    = err_sticky;
    lck_n    = locked;
    miss     = 1'b0;
    if (clr) begin
      nxt      = IDLE;
      prev_n   = '0;
      prev_m_n = 1'b0;
      run_n    = '0;
      stk_n    = 1'b0;
      lck_n    = 1'b0;
    end else if (en) begin
      // direction for this step comes from the stored sample
      prev_n   = count;
      prev_m_n = m;
      if (cur == IDLE) begin
        nxt = ACQ;
      end else if (count != expd) begin
        miss  = 1'b1;
        err_n = 1'b1;
        stk_n = 1'b1;
        run_n = '0;
        lck_n = 1'b0;
        nxt   = RESYNC;
      end else begin
        if (run != LOCK) run_n = run + GR_W'(1);
        if (run_n == LOCK) begin
          nxt   = TRACK;
          lck_n = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur        <= IDLE;
      prev       <= '0;
      prev_m     <= 1'b0;
      run        <= '0;
      err        <= 1'b0;
      err_sticky <= 1'b0;
      locked     <= 1'b0;
    end else begin
      cur        <= nxt;
      prev       <= prev_n;
      prev_m     <= prev_m_n;
      run        <= run_n;
      err        <= err_n;
      err_sticky <= stk_n;
      locked     <= lck_n;
    end
  end

  sat_counter #(.W(ERR_W)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .inc   (miss),
    .count (err_cnt)
  );

  assign state = cur;

endmodule

// File: tb/tb_count_checker.sv
// Bench for count_checker: vector table plus hand sequences,
// expectations queued at drive time and checked after the edge.
module tb_count_checker;

  localparam int S_IDLE = 0;
  localparam int S_ACQ  = 1;
  localparam int S_TRK  = 2;
  localparam int S_RSY  = 3;

  logic       clk = 0;
  logic       rst = 0;
  logic       en = 0, m = 0, clr = 0;
  logic [3:0] count = 0;
  logic       err, err_sticky, locked;
  logic [7:0] err_cnt;
  logic [1:0] state;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic       en, m, clr;
    logic [3:0] cnt;
    logic       e_err, e_lck, e_stk;
    int         e_st, e_ec;
  } vec_t;

  typedef struct {
    logic e_err, e_lck, e_stk;
    int   e_st, e_ec;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  count_checker #(.WIDTH(4), .ERR_W(8), .LOCK_N(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .m          (m),
    .count      (count),
    .clr        (clr),
    .err        (err),
    .err_sticky (err_sticky),
    .err_cnt    (err_cnt),
    .locked     (locked),
    .state      (state)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, req);
    end
  endtask

  task automatic chk_all(input string tag, input exp_t x);
    cmp({tag, ".err"}, 32'(err), 32'(x.e_err));
    cmp({tag, ".locked"}, 32'(locked), 32'(x.e_lck));
    cmp({tag, ".sticky"}, 32'(err_sticky), 32'(x.e_stk));
    cmp({tag, ".state"}, 32'(state), 32'(x.e_st));
    cmp({tag, ".err_cnt"}, 32'(err_cnt), 32'(x.e_ec));
  endtask

  function automatic vec_t mk(input logic e, input logic mm,
                              input int c, input logic cl,
                              input logic xe, input logic xl,
                              input int xs, input int xc,
                              input logic xk);
    vec_t v;
    v.en = e; v.m = mm; v.cnt = 4'(c); v.clr = cl;
    v.e_err = xe; v.e_lck = xl; v.e_st = xs; v.e_ec = xc;
    v.e_stk = xk;
    return v;
  endfunction

  task automatic step(input string tag, input vec_t v);
    exp_t x;
    en = v.en; m = v.m; count = v.cnt; clr = v.clr;
    x.e_err = v.e_err; x.e_lck = v.e_lck; x.e_st = v.e_st;
    x.e_ec = v.e_ec; x.e_stk = v.e_stk;
    sb.push_back(x);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      chk_all(tag, sb.pop_front());
    end
  endtask

  initial begin
    exp_t z;
    z.e_err = 0; z.e_lck = 0; z.e_stk = 0; z.e_st = S_IDLE; z.e_ec = 0;

    #3;
    chk_all("reset", z);
    #4 rst = 1;

    // lock from 0, gap, wraps with direction change carried on sample 1
    tbl.push_back(mk(1, 1, 0,  0, 0, 0, S_ACQ, 0, 0));
    tbl.push_back(mk(1, 1, 1,  0, 0, 0, S_ACQ, 0, 0));
    tbl.push_back(mk(1, 1, 2,  0, 0, 0, S_ACQ, 0, 0));
    tbl.push_back(mk(1, 1, 3,  0, 0, 1, S_TRK, 0, 0));
    tbl.push_back(mk(0, 0, 9,  0, 0, 1, S_TRK, 0, 0));
    tbl.push_back(mk(0, 1, 0,  1, 0, 0, S_IDLE, 0, 0));
    tbl.push_back(mk(1, 1, 14, 0, 0, 0, S_ACQ, 0, 0));
    tbl.push_back(mk(1, 1, 15, 0, 0, 0, S_ACQ, 0, 0));
    tbl.push_back(mk(1, 1, 0,  0, 0, 0, S_ACQ, 0, 0));
    tbl.push_back(mk(1, 0, 1,  0, 0, 1, S_TRK, 0, 0));
    tbl.push_back(mk(1, 0, 0,  0, 0, 1, S_TRK, 0, 0));
    tbl.push_back(mk(1, 0, 15, 0, 0, 1, S_TRK, 0, 0));
    tbl.push_back(mk(1, 0, 14, 0, 0, 1, S_TRK, 0, 0));
    // relock, skip to 9, resync on 10,11,12
    tbl.push_back(mk(0, 1, 0,  1, 0, 0, S_IDLE, 0, 0));
    tbl.push_back(mk(1, 1, 1,  0, 0, 0, S_ACQ, 0, 0));
    tbl.push_back(mk(1, 1, 2,  0, 0, 0, S_ACQ, 0, 0));
    tbl.push_back(mk(1, 1, 3,  0, 0, 0, S_ACQ, 0, 0));
    tbl.push_back(mk(1, 1, 4,  0, 0, 1, S_TRK, 0, 0));
    tbl.push_back(mk(1, 1, 5,  0, 0, 1, S_TRK, 0, 0));
    tbl.push_back(mk(1, 1, 6,  0, 0, 1, S_TRK, 0, 0));
    tbl.push_back(mk(1, 1, 9,  0, 1, 0, S_RSY, 1, 1));
    tbl.push_back(mk(1, 1, 10, 0, 0, 0, S_RSY, 1, 1));
    tbl.push_back(mk(1, 1, 11, 0, 0, 0, S_RSY, 1, 1));
    tbl.push_back(mk(1, 1, 12, 0, 0, 1, S_TRK, 1, 1));
    tbl.push_back(mk(1, 1, 13, 0, 0, 1, S_TRK, 1, 1));
    // step direction is the stored m, not the current one
    tbl.push_back(mk(1, 0, 14, 0, 0, 1, S_TRK, 1, 1));
    tbl.push_back(mk(1, 0, 13, 0, 0, 1, S_TRK, 1, 1));
    // constant count going down is a mismatch
    tbl.push_back(mk(1, 0, 13, 0, 1, 0, S_RSY, 2, 1));
    // clr beats en in RESYNC; next sample acts as a first sample
    tbl.push_back(mk(1, 1, 5,  1, 0, 0, S_IDLE, 0, 0));
    tbl.push_back(mk(1, 1, 9,  0, 0, 0, S_ACQ, 0, 0));
    tbl.push_back(mk(1, 1, 10, 0, 0, 0, S_ACQ, 0, 0));

    for (int i = 0; i < tbl.size(); i++)
      step($sformatf("vec%0d", i), tbl[i]);

    // saturation: held count 7 for 300 samples
    step("sat_clr", mk(0, 1, 0, 1, 0, 0, S_IDLE, 0, 0));
    for (int i = 0; i < 300; i++) begin
      int ec;
      ec = (i > 255) ? 255 : i;
      if (i == 0)
        step("sat0", mk(1, 1, 7, 0, 0, 0, S_ACQ, 0, 0));
      else
        step($sformatf("sat%0d", i),
             mk(1, 1, 7, 0, 1, 0, S_RSY, ec, 1));
    end
    step("sat_idle", mk(0, 1, 7, 0, 0, 0, S_RSY, 255, 1));

    // async reset pulse while locked
    step("pre_clr", mk(0, 1, 0, 1, 0, 0, S_IDLE, 0, 0));
    step("pre0", mk(1, 1, 0, 0, 0, 0, S_ACQ, 0, 0));
    step("pre1", mk(1, 1, 1, 0, 0, 0, S_ACQ, 0, 0));
    step("pre2", mk(1, 1, 2, 0, 0, 0, S_ACQ, 0, 0));
    step("pre3", mk(1, 1, 3, 0, 0, 1, S_TRK, 0, 0));
    en = 0;
    #2 rst = 0;
    #1 chk_all("rst_mid", z);
    #2 rst = 1;
    step("post8",  mk(1, 1, 8,  0, 0, 0, S_ACQ, 0, 0));
    step("post9",  mk(1, 1, 9,  0, 0, 0, S_ACQ, 0, 0));
    step("post10", mk(1, 1, 10, 0, 0, 0, S_ACQ, 0, 0));
    step("post11", mk(1, 1, 11, 0, 0, 1, S_TRK, 0, 0));

    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard: %0d left over", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
